// File: rtl/gray_pkg.sv
// gray_pkg
//   Shared definitions for the Gray-code counter family.
//   - MAX_W     : widest vector the helper functions handle; callers
//                 zero-extend into it and truncate the result.
//   - DIR_UP/DIR_DOWN : encodings of the direction input.
//   - step_e    : classification of what the counter does on an edge,
//                 exported so checkers can observe the decision.
//   - bin2gray / gray2bin : conversion helpers.
package gray_pkg;

    localparam int   MAX_W    = 32;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        STEP_HOLD    = 3'd0,
        STEP_LOAD    = 3'd1,
        STEP_INC     = 3'd2,
        STEP_DEC     = 3'd3,
        STEP_WRAP_UP = 3'd4,
        STEP_WRAP_DN = 3'd5
    } step_e;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Running XOR from the MSB down: b[i] = ^g[MAX_W-1:i]. Zero-extended
    // inputs convert correctly because leading zeros do not change the XOR.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv
//   Purely combinational Gray-to-binary converter of parametrised width.
//   Ports:
//     i_gray [WIDTH-1:0] : Gray-coded input
//     o_bin  [WIDTH-1:0] : binary equivalent, o_bin[i] = ^i_gray[WIDTH-1:i]
module gray2bin_conv #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_updown_counter.sv
// gray_updown_counter
//   Up/down counter that keeps a binary count and presents it Gray-coded.
//   Parameters:
//     WIDTH    : counter width (>= 2)
//     SATURATE : 0 = wrap at range ends, 1 = hold at range ends
//   Ports:
//     clk      : rising-edge clock
//     rst      : synchronous reset, active-low
//     en       : count enable, one step per clock while high
//     y        : direction, 1 = up, 0 = down
//     load     : synchronous load strobe (beats en)
//     load_val : Gray-coded value to load
//     cout     : registered count, Gray-coded
//     bin      : registered count, binary (also the raw state)
//     tc       : terminal count in the current direction (combinational)
//     wrap     : one-cycle pulse, the previous edge wrapped around
//     o_step   : debug view of the decision taken on the coming edge
//   No handshake: inputs are sampled on every rising edge.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             y,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cout,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             wrap,
    output step_e            o_step
);

    logic [WIDTH-1:0] r_b;
    logic             r_wrap;
    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_b_next;
    logic             w_wrap_next;
    logic             w_at_max;
    logic             w_at_min;
    step_e            w_step;

    gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
        .i_gray (load_val),
        .o_bin  (w_load_bin)
    );

    assign w_at_max = (r_b == {WIDTH{1'b1}});
    assign w_at_min = (r_b == {WIDTH{1'b0}});

    // Decide what happens on the next edge; reset is handled in the register.
    always_comb begin
        w_step = STEP_HOLD;
        if (load) begin
            w_step = STEP_LOAD;
        end else if (en) begin
            case (y)
                DIR_UP: begin
                    if (!w_at_max)     w_step = STEP_INC;
                    else if (!SATURATE) w_step = STEP_WRAP_UP;
                end
                DIR_DOWN: begin
                    if (!w_at_min)     w_step = STEP_DEC;
                    else if (!SATURATE) w_step = STEP_WRAP_DN;
                end
                default: w_step = STEP_HOLD;
            endcase
        end
    end

    always_comb begin
        w_b_next    = r_b;
        w_wrap_next = 1'b0;
        case (w_step)
            STEP_LOAD:    w_b_next = w_load_bin;
            STEP_INC:     w_b_next = r_b + 1'b1;
            STEP_DEC:     w_b_next = r_b - 1'b1;
            STEP_WRAP_UP: begin
                w_b_next    = {WIDTH{1'b0}};
                w_wrap_next = 1'b1;
            end
            STEP_WRAP_DN: begin
                w_b_next    = {WIDTH{1'b1}};
                w_wrap_next = 1'b1;
            end
            default: w_b_next = r_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_b    <= {WIDTH{1'b0}};
            r_wrap <= 1'b0;
        end else begin
            r_b    <= w_b_next;
            r_wrap <= w_wrap_next;
        end
    end

    // Gray output is derived from the binary state, never stored separately.
    assign cout   = WIDTH'(bin2gray(MAX_W'(r_b)));
    assign bin    = r_b;
    assign wrap   = r_wrap;
    assign tc     = (y & w_at_max) | (~y & w_at_min);
    assign o_step = w_step;

endmodule

// File: doc/gray_updown_counter.md
# gray_updown_counter

Parametrised up/down Gray-code counter, the WIDTH-generic successor of the 3-bit Gray counter used in the PTA lab designs. It keeps a binary count internally and presents a registered Gray-coded value, plus the binary equivalent. Beyond plain stepping, it adds:
- a count enable;
- a synchronous parallel load of a Gray-coded value;
- a wrap or saturate end-of-range mode;
- terminal-count and wrap-event flags.

It drives Gray-coded pointers and position encoders in the lab datapath.

## Interface
- WIDTH, 3: counter width in bits, ≥2.
- SATURATE, 0: 0 = wrap at range ends; 1 = hold at range ends.
- clk  in  1: rising-edge clock.
- rst  in  1: synchronous reset, active-low.
- en  in  1: count enable; the counter steps once per clk while high.
- y  in  1: direction; 1 = up (next Gray code), 0 = down (previous Gray code).
- load  in  1: synchronous load strobe.
- load_val  in  WIDTH: Gray-coded value to load.
- cout  out  WIDTH: current count, Gray-coded, registered.
- bin  out  WIDTH: current count, binary, registered.
- tc  out  1: terminal count, combinational from state and y.
- wrap  out  1: registered one-cycle pulse; the previous edge wrapped.

## Operation
- State: a binary register b[WIDTH-1:0]. Outputs: cout = b ^ (b >> 1), and bin = b. Never store Gray separately.
- Priority on each rising clk edge:
  1. rst low: b = 0 and wrap = 0.
  2. Otherwise load high: b = gray2bin(load_val) and wrap = 0. en and y are ignored.
  3. Otherwise en high and y = 1:
     - b all-ones, SATURATE = 0: b = 0, wrap = 1.
     - b all-ones, SATURATE = 1: b holds, wrap = 0.
     - Otherwise: b = b + 1, wrap = 0.
  4. Otherwise en high and y = 0:
     - b = 0, SATURATE = 0: b = all-ones, wrap = 1.
     - b = 0, SATURATE = 1: b holds, wrap = 0.
     - Otherwise: b = b − 1, wrap = 0.
  5. Otherwise: b holds, wrap = 0.
- All arithmetic is modulo 2^WIDTH. No carry-out beyond the wrap flag.
- tc = (y & (b == all-ones)) | (~y & (b == 0)). It is independent of en and SATURATE.
- Every step changes exactly one bit of cout. Loads and resets may change several.
- Effective FSM: 2^WIDTH states, ordered by b. With WIDTH=3 the Gray sequence is 000, 001, 011, 010, 110, 111, 101, 100, then back to 000.

## Timing
- Reset values: b = 0, cout = 0, bin = 0, wrap = 0. tc = ~y, because b = 0.
- Latency: one clk from en, y or load to cout and bin. tc follows y combinationally in the same cycle. wrap is visible in the cycle after the wrapping edge, for exactly one cycle.
- rst is sampled only on clk. A rst pulse between edges has no effect. rst low during a load or step aborts it.
- load with en simultaneously high: load wins, and no step occurs in that cycle.
- A y change while en is high takes effect at the next edge, with no dead cycle.
- No handshakes. en may be held high indefinitely; the counter then wraps every 2^WIDTH cycles.

## Structure
- Shared package `gray_pkg`:
  - function `bin2gray(x)` = x ^ (x >> 1);
  - function `gray2bin(g)`: prefix XOR from the MSB, b[i] = ^g[WIDTH-1:i];
  - localparams for the direction encodings DIR_UP = 1 and DIR_DOWN = 0.
- One sub-module, `gray2bin_conv`: parametrised combinational converter, instantiated on load_val. It is kept separate so later Gray-pointer synchronisers can reuse it.
- The top holds the b register, the next-state logic, the wrap register and the tc logic.

## Test plan
- Reset/up count, WIDTH=3: rst low for 2 clk, then en=1, y=1 for 9 clk -> cout = 000, 001, 011, 010, 110, 111, 101, 100, 000. wrap high only in the cycle cout returns to 000. tc = 1 while cout = 100.
- Down wrap, WIDTH=3, SATURATE=0: from reset, en=1, y=0 -> cout = 100, 101, 111 and so on. wrap pulses after the first edge. tc = 1 while b = 0.
- Saturate, WIDTH=4, SATURATE=1: load load_val = 4'b1000 (b = 15), then en=1, y=1 for 3 clk -> cout stays 1000, wrap stays 0, tc = 1. Then y=0 -> cout = 1001 (b = 14).
- Load priority, WIDTH=4: load=1, en=1, y=1, load_val = 4'b0110 -> next cout = 0110, bin = 0100, no step. Next edge with load=0 -> cout = 0111.
- Mid-operation reset: count up to b = 5, then assert rst low for 1 clk with en=1 -> next cout = 0 and wrap = 0. Deassert -> counting resumes 0, 1, ...
- Property sweep, WIDTH=8, random en/y/load: every non-load, non-reset step changes exactly one cout bit; the bench asserts gray2bin(cout) == bin on every cycle.
